// File: rtl/ex_completion_sched.sv
// ex_completion_sched: execute-side responder to the reservation station.
// Each RS entry owns one execution slot. A slot counts down its functional-unit
// latency, then requests the single CDB. The granted slot broadcasts its tag and
// tells the RS which entry to free.
// Optional build macro EX_SCHED_RR_ARB_EN selects a round-robin arbiter in place of
// the default fixed priority 3 > 4 > 1 > 0 > 2.
module ex_completion_sched #(
    parameter int TAG_W    = 6,
    parameter int RS_SZ    = 5,
    parameter int ALU_LAT  = 1,
    parameter int MEM_LAT  = 2,
    parameter int MULT_LAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             interrupt,
    input  logic             issue_en,
    input  logic [2:0]       issue_rs_idx,
    input  logic             issue_dest_valid,
    input  logic [TAG_W-1:0] issue_dest_tag,
    output logic             is_stall,
    output logic [TAG_W-1:0] cdb,
    output logic             cdb_en,
    output logic             remove_en,
    output logic [2:0]       remove_idx,
    output logic [RS_SZ-1:0] slot_busy
);

    localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ?
                             ((ALU_LAT > MULT_LAT) ? ALU_LAT : MULT_LAT) :
                             ((MEM_LAT > MULT_LAT) ? MEM_LAT : MULT_LAT);
    // The counter only has to hold LAT-1.
    localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Slot 0 is the ALU, slots 1-2 are load/store, every higher slot is a multiplier.
    function automatic int lat_of(input int s);
        if (s == 0)      return ALU_LAT;
        else if (s <= 2) return MEM_LAT;
        else             return MULT_LAT;
    endfunction

    logic [RS_SZ-1:0] busy_q, busy_d;
    logic [RS_SZ-1:0] dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q [RS_SZ];
    logic [CNT_W-1:0] cnt_d [RS_SZ];
    logic [TAG_W-1:0] tag_q [RS_SZ];
    logic [TAG_W-1:0] tag_d [RS_SZ];

    logic [TAG_W-1:0] cdb_q, cdb_d;
    logic             cdb_en_q, cdb_en_d;
    logic             remove_en_q, remove_en_d;
    logic [2:0]       remove_idx_q, remove_idx_d;

    logic             idx_busy;
    logic             accept;
    logic [7:0]       req;
    logic             gnt_valid;
    logic             gnt_fire;
    logic [2:0]       gnt_idx;
    logic             gnt_dest;
    logic [TAG_W-1:0] gnt_tag;

    // Stall decision for the presented issue; the interrupt cycle always stalls.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        idx_busy = 1'b0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (issue_rs_idx == 3'(i)) idx_busy = busy_q[i];
        end
        is_stall = issue_en && ((int'(issue_rs_idx) >= RS_SZ) || idx_busy || interrupt);
        accept   = issue_en && !is_stall;
    end

    // A slot requests the CDB once its countdown has reached zero; unused bits stay low.
    always_comb begin
        req = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            req[i] = busy_q[i] && (cnt_q[i] == '0);
        end
    end

`ifdef EX_SCHED_RR_ARB_EN
    logic [2:0] ptr_q, ptr_d;
    int         probe;

    // Round-robin: search starts at the slot after the last grant and wraps.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        probe     = 0;
        for (int k = 0; k < RS_SZ; k++) begin
            probe = (int'(ptr_q) + k) % RS_SZ;
            if (!gnt_valid && req[probe]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 3'(probe);
            end
        end
        ptr_d = (int'(gnt_idx) + 1 >= RS_SZ) ? 3'd0 : gnt_idx + 3'd1;
    end

    // Pointer moves only when a grant is actually taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        ptr_q <= '0;
        else if (gnt_fire) ptr_q <= ptr_d;
    end
`else
    localparam int PRIO [5] = '{3, 4, 1, 0, 2};

    // Fixed priority 3 > 4 > 1 > 0 > 2; any slots beyond 4 rank last in index order.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < 5; k++) begin
            if (!gnt_valid && req[PRIO[k]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 3'(PRIO[k]);
            end
        end
        for (int i = 5; i < 8; i++) begin
            if (!gnt_valid && req[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = 3'(i);
            end
        end
    end
`endif

    // Fetch the winner's payload and drop the grant when a flush is in progress.
    always_comb begin
        gnt_fire = gnt_valid && !interrupt;
        gnt_dest = 1'b0;
        gnt_tag  = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (gnt_idx == 3'(i)) begin
                gnt_dest = dest_q[i];
                gnt_tag  = tag_q[i];
            end
        end
    end

    // Slot next state: flush beats grant beats accept beats countdown.
    always_comb begin
        busy_d = busy_q;
        dest_d = dest_q;
        cnt_d  = cnt_q;
        tag_d  = tag_q;
        for (int i = 0; i < RS_SZ; i++) begin
            if (interrupt) begin
                busy_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end else if (gnt_valid && gnt_idx == 3'(i)) begin
                busy_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end else if (accept && issue_rs_idx == 3'(i)) begin
                busy_d[i] = 1'b1;
                cnt_d[i]  = CNT_W'(lat_of(i) - 1);
                tag_d[i]  = issue_dest_tag;
                dest_d[i] = issue_dest_valid;
            end else if (busy_q[i] && cnt_q[i] != '0) begin
                cnt_d[i]  = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Completion outputs: cdb and remove_idx keep their last value between grants.
    always_comb begin
        remove_en_d  = gnt_fire;
        remove_idx_d = gnt_fire ? gnt_idx : remove_idx_q;
        cdb_en_d     = gnt_fire && gnt_dest;
        cdb_d        = (gnt_fire && gnt_dest) ? gnt_tag : cdb_q;
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the slot arrays are a handful of flops, not a RAM, so they are reset
            // like any other register and a mid-countdown reset leaves nothing behind.
            busy_q <= '0;
            dest_q <= '0;
            for (int i = 0; i < RS_SZ; i++) begin
                cnt_q[i] <= '0;
                tag_q[i] <= '0;
            end
            cdb_q        <= '0;
            cdb_en_q     <= 1'b0;
            remove_en_q  <= 1'b0;
            remove_idx_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            busy_q       <= busy_d;
            dest_q       <= dest_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            cdb_q        <= cdb_d;
            cdb_en_q     <= cdb_en_d;
            remove_en_q  <= remove_en_d;
            remove_idx_q <= remove_idx_d;
        end
    end

    assign cdb        = cdb_q;
    assign cdb_en     = cdb_en_q;
    assign remove_en  = remove_en_q;
    assign remove_idx = remove_idx_q;
    assign slot_busy  = busy_q;

endmodule
